// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART receiver bytes with framing flag into a FWFT FIFO with sticky overrun
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rdrf,
  input  logic                   FE,
  output logic                   rdrf_clr,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_fe,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   ovr_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, WAIT_LOW} state_t;
  state_t state_q, state_d;
  logic rdrf_clr_q, rdrf_clr_d, overrun_q, overrun_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH:0] mem_q [DEPTH];
  logic [WIDTH:0] mem_d [DEPTH];
  logic cap, wr, pop, drop;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(DEPTH);
  assign count    = count_q;
  assign overrun  = overrun_q;
  assign rdrf_clr = rdrf_clr_q;
  assign rd_data  = mem_q[rp_q][WIDTH-1:0];
  assign rd_fe    = mem_q[rp_q][WIDTH];
  // next-state: capture once per rdrf assertion; a full FIFO only accepts when popped in the same cycle
  always_comb begin
    cap        = state_q == IDLE && rdrf;
    pop        = rd_en && !empty;
    wr         = cap && (!full || rd_en);
    drop       = cap && full && !rd_en;
    state_d    = state_q == IDLE ? (rdrf ? WAIT_LOW : IDLE) : (rdrf ? WAIT_LOW : IDLE);
    rdrf_clr_d = cap;
    wp_d       = wr ? wp_q + 1'b1 : wp_q;
    rp_d       = pop ? rp_q + 1'b1 : rp_q;
    count_d    = count_q + CW'(wr) - CW'(pop);
    overrun_d  = drop || (overrun_q && !ovr_clr);
    mem_d      = mem_q;
    if (wr) mem_d[wp_q] = {FE, rx_data};
  end
  // control state, pointers, occupancy and flags
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      rdrf_clr_q <= 1'b0;
      overrun_q  <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rdrf_clr_q <= rdrf_clr_d;
      overrun_q  <= overrun_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
    end
  end
  // storage needs no reset; contents are don't-care while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
